// File: rtl/sbox_arb_if.sv
// Bundle of the KS/DP request-grant-response channels and the external S-box
// port that the sbox_arbiter shares between its two requesters.
// master: requester/S-box side (drives requests, bytes and sbox_out)
// slave : arbiter side (drives grants, responses, sbox_in and busy)
interface sbox_arb_if;
  logic       ks_req;
  logic [7:0] ks_byte;
  logic       ks_gnt;
  logic       ks_rvalid;
  logic [7:0] ks_rdata;
  logic       dp_req;
  logic [7:0] dp_byte;
  logic       dp_gnt;
  logic       dp_rvalid;
  logic [7:0] dp_rdata;
  logic [7:0] sbox_in;
  logic [7:0] sbox_out;
  logic       busy;

  modport master (
    output ks_req, ks_byte, dp_req, dp_byte, sbox_out,
    input  ks_gnt, ks_rvalid, ks_rdata, dp_gnt, dp_rvalid, dp_rdata, sbox_in, busy
  );

  modport slave (
    input  ks_req, ks_byte, dp_req, dp_byte, sbox_out,
    output ks_gnt, ks_rvalid, ks_rdata, dp_gnt, dp_rvalid, dp_rdata, sbox_in, busy
  );
endinterface

// File: rtl/sbox_arbiter.sv
// sbox_arbiter: shares one external combinational AES S-box between the key
// schedule (KS) and the round datapath (DP). One lookup is granted per cycle,
// its byte is registered onto sbox_in, and the S-box result is registered back
// to the owning requester one cycle later (grant -> rvalid latency of 2).
//
// Build option SBOX_ARB_RR_EN:
//   defined   - round-robin arbitration, the requester not granted last wins
//               contention; the DP wait counter is not built.
//   undefined - KS has fixed priority, with a DP starvation guard that forces
//               one DP grant after MAX_WAIT consecutive losing cycles.
module sbox_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input logic       clk,
  input logic       rst_n,
  sbox_arb_if.slave bus
);

  logic       w_ksGnt;
  logic       w_dpGnt;
  logic       w_anyGnt;
  logic [7:0] w_gntByte;

  logic       r_s1Valid;
  logic       r_s1OwnerDp;
  logic [7:0] r_sboxIn;
  logic       r_ksRvalid;
  logic       r_dpRvalid;
  logic [7:0] r_ksRdata;
  logic [7:0] r_dpRdata;

`ifdef SBOX_ARB_RR_EN

  // Points at the requester that wins the next contention; starts on KS.
  logic r_rrPrefKs;

  // Grant whoever is alone, otherwise whoever the pointer favours.
  always_comb begin
    w_ksGnt = 1'b0;
    w_dpGnt = 1'b0;
    if (rst_n) begin
      w_ksGnt = bus.ks_req & (~bus.dp_req | r_rrPrefKs);
      w_dpGnt = bus.dp_req & (~bus.ks_req | ~r_rrPrefKs);
    end
  end

  // Every grant hands preference to the other requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPrefKs <= 1'b1;
    end else if (w_ksGnt) begin
      r_rrPrefKs <= 1'b0;
    end else if (w_dpGnt) begin
      r_rrPrefKs <= 1'b1;
    end
  end

`else

  localparam logic [CNT_W-1:0] LP_MAX_WAIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_waitCnt;
  logic             w_dpForce;

  // Once DP has lost MAX_WAIT cycles in a row it takes the next contention.
  always_comb begin
    w_dpForce = (r_waitCnt == LP_MAX_WAIT);
    w_ksGnt   = 1'b0;
    w_dpGnt   = 1'b0;
    if (rst_n) begin
      w_ksGnt = bus.ks_req & ~(bus.dp_req & w_dpForce);
      w_dpGnt = bus.dp_req & (~bus.ks_req | w_dpForce);
    end
  end

  // Count consecutive cycles DP waits; a grant or a dropped request clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (!bus.dp_req || w_dpGnt) begin
      r_waitCnt <= '0;
    end else if (r_waitCnt != LP_MAX_WAIT) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

`endif

  // Select the byte of whichever requester was granted this cycle.
  always_comb begin
    w_anyGnt  = w_ksGnt | w_dpGnt;
    w_gntByte = w_dpGnt ? bus.dp_byte : bus.ks_byte;
  end

  // Stage 1: launch the granted byte onto the S-box and remember its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid   <= 1'b0;
      r_s1OwnerDp <= 1'b0;
      r_sboxIn    <= 8'h00;
    end else begin
      r_s1Valid   <= w_anyGnt;
      r_s1OwnerDp <= w_dpGnt;
      if (w_anyGnt) begin
        r_sboxIn <= w_gntByte;
      end
    end
  end

  // Stage 2: capture the S-box result into the owner's response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ksRvalid <= 1'b0;
      r_dpRvalid <= 1'b0;
      r_ksRdata  <= 8'h00;
      r_dpRdata  <= 8'h00;
    end else begin
      r_ksRvalid <= r_s1Valid & ~r_s1OwnerDp;
      r_dpRvalid <= r_s1Valid & r_s1OwnerDp;
      if (r_s1Valid && !r_s1OwnerDp) begin
        r_ksRdata <= bus.sbox_out;
      end
      if (r_s1Valid && r_s1OwnerDp) begin
        r_dpRdata <= bus.sbox_out;
      end
    end
  end

  assign bus.ks_gnt    = w_ksGnt;
  assign bus.dp_gnt    = w_dpGnt;
  assign bus.ks_rvalid = r_ksRvalid;
  assign bus.dp_rvalid = r_dpRvalid;
  assign bus.ks_rdata  = r_ksRdata;
  assign bus.dp_rdata  = r_dpRdata;
  assign bus.sbox_in   = r_sboxIn;
  assign bus.busy      = r_s1Valid | r_ksRvalid | r_dpRvalid;

endmodule
